// File: rtl/chacha_block_sequencer.sv
// chacha_block_sequencer: control FSM that walks one shared ChaCha quarter-round
// core through ROUNDS rounds. It then runs the 16-word feed-forward and presents
// the 16 output word indices. It holds no state words itself.
// Optional feature macro: CHACHA_SEQ_HCHACHA_EN adds the hmode port (HChaCha:
// no feed-forward, 8 output words, no counter increment).
// Handshakes: a request on qr_* or out_* transfers on the cycle where its
// valid and the matching ready are both high at the rising clock edge. Valid
// and the indices stay stable until that edge. qr_done is a single-cycle
// completion strobe and is only observed while a request is outstanding.
module chacha_block_sequencer #(
   parameter int ROUNDS = 20
) (
   input  logic       clk,
   input  logic       rstb,
   input  logic       start,
   input  logic       abort,
`ifdef CHACHA_SEQ_HCHACHA_EN
   input  logic       hmode,
`endif
   output logic       busy,
   output logic       done,
   output logic       ctr_inc,
   output logic       qr_valid,
   input  logic       qr_ready,
   input  logic       qr_done,
   output logic [3:0] qr_a,
   output logic [3:0] qr_b,
   output logic [3:0] qr_c,
   output logic [3:0] qr_d,
   output logic       ff_we,
   output logic [3:0] ff_idx,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_idx,
   output logic [2:0] dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_FEED  = 3'd3,
      S_OUT   = 3'd4
   } state_t;

   localparam logic [4:0] LAST_RND = 5'(ROUNDS - 1);

   state_t      state_q, state_d;
   logic [1:0]  qr_cnt_q, qr_cnt_d;
   logic [4:0]  rnd_cnt_q, rnd_cnt_d;
   logic [3:0]  ff_cnt_q, ff_cnt_d;
   logic [3:0]  out_cnt_q, out_cnt_d;
   logic        hmode_q, hmode_d;
   logic        hmode_in;
   logic [3:0]  out_last;

   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        ctr_inc_q, ctr_inc_d;
   logic        qr_valid_q, qr_valid_d;
   logic [15:0] qr_idx_q, qr_idx_d;
   logic        ff_we_q, ff_we_d;
   logic [3:0]  ff_idx_q, ff_idx_d;
   logic        out_valid_q, out_valid_d;
   logic [3:0]  out_idx_q, out_idx_d;

`ifdef CHACHA_SEQ_HCHACHA_EN
   assign hmode_in = hmode;
`else
   assign hmode_in = 1'b0;
`endif

   // Quarter-round word indices {a,b,c,d}: column round, or the diagonal
   // rotation of rows b/c/d by 1/2/3 positions.
   function automatic logic [15:0] qr_indices(input logic [1:0] i, input logic diag);
      logic [1:0] ib;
      logic [1:0] ic;
      logic [1:0] id;
      ib = diag ? (i + 2'd1) : i;
      ic = diag ? (i + 2'd2) : i;
      id = diag ? (i + 2'd3) : i;
      return {2'b00, i, 2'b01, ib, 2'b10, ic, 2'b11, id};
   endfunction

   // HChaCha presents words 0..3 then 12..15, so ordinal 4..7 maps to 12..15.
   function automatic logic [3:0] out_map(input logic [3:0] cnt, input logic hm);
      return hm ? {cnt[2], cnt[2], cnt[1:0]} : cnt;
   endfunction

   assign out_last = hmode_q ? 4'd7 : 4'd15;

   // Next-state, counter and registered-output computation; abort wins over everything.
   always_comb begin
      state_d   = state_q;
      qr_cnt_d  = qr_cnt_q;
      rnd_cnt_d = rnd_cnt_q;
      ff_cnt_d  = ff_cnt_q;
      out_cnt_d = out_cnt_q;
      hmode_d   = hmode_q;
      done_d    = 1'b0;
      ctr_inc_d = 1'b0;
      qr_idx_d  = 16'h0000;

      if (abort) begin
         state_d   = S_IDLE;
         qr_cnt_d  = 2'd0;
         rnd_cnt_d = 5'd0;
         ff_cnt_d  = 4'd0;
         out_cnt_d = 4'd0;
         hmode_d   = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d   = S_ISSUE;
                  qr_cnt_d  = 2'd0;
                  rnd_cnt_d = 5'd0;
                  ff_cnt_d  = 4'd0;
                  out_cnt_d = 4'd0;
                  hmode_d   = hmode_in;
               end
            end
            S_ISSUE: begin
               if (qr_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
               if (qr_done) begin
                  qr_cnt_d = qr_cnt_q + 2'd1;
                  if (qr_cnt_q == 2'd3) rnd_cnt_d = rnd_cnt_q + 5'd1;
                  if ((qr_cnt_q == 2'd3) && (rnd_cnt_q == LAST_RND))
                     state_d = hmode_q ? S_OUT : S_FEED;
                  else
                     state_d = S_ISSUE;
               end
            end
            S_FEED: begin
               ff_cnt_d = ff_cnt_q + 4'd1;
               if (ff_cnt_q == 4'd15) state_d = S_OUT;
            end
            S_OUT: begin
               if (out_ready) begin
                  if (out_cnt_q == out_last) begin
                     state_d   = S_IDLE;
                     out_cnt_d = 4'd0;
                     done_d    = 1'b1;
                     ctr_inc_d = ~hmode_q;
                  end else begin
                     out_cnt_d = out_cnt_q + 4'd1;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      busy_d      = (state_d != S_IDLE);
      qr_valid_d  = (state_d == S_ISSUE);
      ff_we_d     = (state_d == S_FEED);
      out_valid_d = (state_d == S_OUT);
      ff_idx_d    = ff_we_d ? ff_cnt_d : 4'd0;
      out_idx_d   = out_valid_d ? out_map(out_cnt_d, hmode_d) : 4'd0;
      if (state_d == S_ISSUE)
         qr_idx_d = qr_indices(qr_cnt_d, rnd_cnt_d[0]);
      else if (state_d == S_WAIT)
         qr_idx_d = qr_idx_q;
   end

   // State, counters and all outputs are registered; reset clears everything.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q     <= S_IDLE;
         qr_cnt_q    <= 2'd0;
         rnd_cnt_q   <= 5'd0;
         ff_cnt_q    <= 4'd0;
         out_cnt_q   <= 4'd0;
         hmode_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ctr_inc_q   <= 1'b0;
         qr_valid_q  <= 1'b0;
         qr_idx_q    <= 16'h0000;
         ff_we_q     <= 1'b0;
         ff_idx_q    <= 4'd0;
         out_valid_q <= 1'b0;
         out_idx_q   <= 4'd0;
      end else begin
         state_q     <= state_d;
         qr_cnt_q    <= qr_cnt_d;
         rnd_cnt_q   <= rnd_cnt_d;
         ff_cnt_q    <= ff_cnt_d;
         out_cnt_q   <= out_cnt_d;
         hmode_q     <= hmode_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         ctr_inc_q   <= ctr_inc_d;
         qr_valid_q  <= qr_valid_d;
         qr_idx_q    <= qr_idx_d;
         ff_we_q     <= ff_we_d;
         ff_idx_q    <= ff_idx_d;
         out_valid_q <= out_valid_d;
         out_idx_q   <= out_idx_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign ctr_inc   = ctr_inc_q;
   assign qr_valid  = qr_valid_q;
   assign qr_a      = qr_idx_q[15:12];
   assign qr_b      = qr_idx_q[11:8];
   assign qr_c      = qr_idx_q[7:4];
   assign qr_d      = qr_idx_q[3:0];
   assign ff_we     = ff_we_q;
   assign ff_idx    = ff_idx_q;
   assign out_valid = out_valid_q;
   assign out_idx   = out_idx_q;
   assign dbg_state = state_q;

endmodule

// File: doc/chacha_block_sequencer.md
# chacha_block_sequencer

Control FSM that sequences one shared ChaCha quarter-round core, feed-forward adder and output port through a complete keystream block. Sits between the command front end (UART/Wishbone decode) and the ChaCha datapath inside the accelerator. It owns no state words. It issues quarter-round word indices, feed-forward strobes and output-word indices, and it pulses the block-counter increment.

## Interface
- `ROUNDS`, default 20: total rounds, even, legal values 8/12/20. Half of them are column rounds and half are diagonal rounds.
- `clk` input 1: single clock, rising edge.
- `rstb` input 1: asynchronous active-low reset.
- `start` input 1: begin one block. Sampled only in IDLE.
- `abort` input 1: synchronous cancel, any state.
- `hmode` input 1: HChaCha mode, sampled with `start`. Exists only with `CHACHA_SEQ_HCHACHA_EN`.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when the block finishes.
- `ctr_inc` output 1: one-cycle pulse that advances state word 12.
- `qr_valid` output 1: quarter-round request.
- `qr_ready` input 1: core accepts the request.
- `qr_done` input 1: core has written back its result.
- `qr_a`, `qr_b`, `qr_c`, `qr_d` output 4 each: state word indices for the request.
- `ff_we` output 1: feed-forward write strobe (working[i] += initial[i]).
- `ff_idx` output 4: feed-forward word index.
- `out_valid` output 1: output word available.
- `out_ready` input 1: downstream accepts the output word.
- `out_idx` output 4: index of the state word being presented.

## Operation
- States: IDLE, ISSUE, WAIT, FEED, OUT.
- IDLE → ISSUE on `start`. Clear `qr_cnt` (2b) and `rnd_cnt` (5b). Latch `hmode`.
- ISSUE: `qr_valid`=1 and the indices are stable. On `qr_valid & qr_ready`, go to WAIT.
- WAIT: hold `qr_valid`=0. On `qr_done`:
  - Increment `qr_cnt`.
  - If `qr_cnt` wraps from 3, increment `rnd_cnt`.
  - If `rnd_cnt`=ROUNDS-1 and `qr_cnt`=3, go to FEED. Otherwise go to ISSUE.
- Index schedule, with i=`qr_cnt`:
  - Even `rnd_cnt` (column round): (i, 4+i, 8+i, 12+i).
  - Odd `rnd_cnt` (diagonal round): (i, 4+((i+1) mod 4), 8+((i+2) mod 4), 12+((i+3) mod 4)). All additions are mod 4 on the low 2 bits.
- FEED: `ff_we`=1 for 16 consecutive cycles with `ff_idx`=0..15, then go to OUT.
- OUT: `out_valid`=1 with `out_idx`=0..15. Each index advances on `out_valid & out_ready`. After index 15 is accepted, pulse `done` and `ctr_inc` in the same cycle and go to IDLE.
- `qr_done` is ignored outside WAIT. `qr_ready` is ignored outside ISSUE. `start` is ignored while `busy`.
- `abort`, when sampled high: go to IDLE on the next edge and clear all counters. No `done` or `ctr_inc` is produced. `abort` takes priority over every simultaneous event.
- Only one quarter-round is outstanding at a time. The core's latency is unbounded; WAIT holds until `qr_done`.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0. This holds for `qr_a`..`qr_d`, `ff_idx` and `out_idx`.
- `start` high at edge N gives `qr_valid`=1 with indices (0,4,8,12) after edge N. `busy` rises on the same edge.
- If `qr_ready` is held at 1 and `qr_done` arrives one cycle after accept, each quarter-round takes 2 cycles. A 20-round block then takes 160 cycles of rounds, plus 16 FEED cycles, plus 16 OUT cycles (with `out_ready`=1). `done` asserts on cycle 192 after `start`.
- All outputs are registered; no combinational path runs from inputs to outputs.
- `rstb` is asserted asynchronously mid-block. Outputs clear immediately. Deassertion is synchronised externally.

## Configuration
- `CHACHA_SEQ_HCHACHA_EN` defined: the `hmode` port exists. With `hmode`=1:
  - FEED is skipped; rounds go directly to OUT.
  - OUT presents only the indices 0,1,2,3,12,13,14,15.
  - `ctr_inc` is not pulsed. `done` still pulses.
- Not defined: there is no `hmode` port, and the behaviour is always ChaCha.

## Test plan
- Reset with `ROUNDS`=20, `start` pulse, `qr_ready`=1, `qr_done` 1 cycle after accept, `out_ready`=1 → 80 requests. Requests 0–3 are (0,4,8,12)..(3,7,11,15). Requests 4–7 are (0,5,10,15),(1,6,11,12),(2,7,8,13),(3,4,9,14). `done` and `ctr_inc` assert on cycle 192.
- Random `qr_ready` and `qr_done` delays of 0–7 cycles, plus spurious `qr_done` in ISSUE → the request sequence is unchanged and no extra requests are issued.
- `out_ready` toggling 1/0 during OUT → each `out_idx` is held until accepted. All 16 indices are emitted in order, each exactly once.
- `abort` in WAIT of round 7, simultaneous with `qr_done` → IDLE the next cycle, no `done`. A following `start` restarts at (0,4,8,12).
- `rstb` low during FEED at `ff_idx`=5 → all outputs 0 immediately. `start` while `busy` is ignored.
- With `CHACHA_SEQ_HCHACHA_EN` and `hmode`=1, `ROUNDS`=20 → no `ff_we`. `out_idx` sequence is 0,1,2,3,12,13,14,15. `done`=1, `ctr_inc`=0.
